// File: rtl/phaser_out_pkg.sv
// Shared types and widths for the write-path phaser controller.
package phaser_out_pkg;

    typedef enum logic [1:0] {
        RESET      = 2'd0,
        LOCK_WAIT  = 2'd1,
        SERDES_RST = 2'd2,
        READY      = 2'd3
    } state_t;

    localparam int FINE_W   = 6;
    localparam int COARSE_W = 9;
    localparam int FINE_MAX = 63;

endpackage

// File: rtl/phaser_tap_ctr.sv
// Saturating up/down tap register with optional parallel load.
// Out-of-range moves or loads leave the tap alone and flag a one-cycle overflow.
module phaser_tap_ctr #(
    parameter int WIDTH = 6,
    parameter int MAX   = 63,
    parameter int INIT  = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_inc,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_tap,
    output logic             o_overflow,
    output logic             o_accept
);

    localparam logic [WIDTH-1:0] L_MAX  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] L_INIT = WIDTH'(INIT);

    logic [WIDTH-1:0] r_tap;
    logic             r_overflow;
    logic [WIDTH-1:0] w_next_tap;
    logic             w_overflow;
    logic             w_accept;

    // Load outranks a step; o_accept marks any request that is applied.
    always_comb begin
        w_next_tap = r_tap;
        w_overflow = 1'b0;
        w_accept   = 1'b0;
        if (i_load) begin
            if (i_load_val > L_MAX) begin
                w_overflow = 1'b1;
            end else begin
                w_next_tap = i_load_val;
                w_accept   = 1'b1;
            end
        end else if (i_en) begin
            if (i_inc) begin
                if (r_tap == L_MAX) begin
                    w_overflow = 1'b1;
                end else begin
                    w_next_tap = r_tap + WIDTH'(1);
                    w_accept   = 1'b1;
                end
            end else begin
                if (r_tap == '0) begin
                    w_overflow = 1'b1;
                end else begin
                    w_next_tap = r_tap - WIDTH'(1);
                    w_accept   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tap      <= L_INIT;
            r_overflow <= 1'b0;
        end else begin
            r_tap      <= w_next_tap;
            r_overflow <= w_overflow;
        end
    end

    assign o_tap      = r_tap;
    assign o_overflow = r_overflow;
    assign o_accept   = w_accept;

endmodule

// File: rtl/phaser_out_ctl.sv
// Write-path phaser controller: lock/OSERDES reset sequencing, fine and coarse
// output delay taps with settle tracking, coarse read-back and DQS/DQ OE windows.
module phaser_out_ctl
    import phaser_out_pkg::*;
#(
    parameter int FINE_DELAY         = 0,
    parameter int COARSE_MAX         = 511,
    parameter int LOCK_CYCLES        = 32,
    parameter int OSERDES_RST_CYCLES = 8,
    parameter int SETTLE_CYCLES      = 4,
    parameter int POSTAMBLE_CYCLES   = 2
) (
    input  logic                SYSCLK,
    input  logic                RST_N,
    input  logic                RST,
    input  logic                FINEENABLE,
    input  logic                FINEINC,
    input  logic                COARSEENABLE,
    input  logic                COARSEINC,
    input  logic                COUNTERLOADEN,
    input  logic [COARSE_W-1:0] COUNTERLOADVAL,
    input  logic                COUNTERREADEN,
    input  logic                BURSTPENDING,
    output logic [COARSE_W-1:0] COUNTERREADVAL,
    output logic [FINE_W-1:0]   FINETAP,
    output logic                FINEOVERFLOW,
    output logic                COARSEOVERFLOW,
    output logic                OSERDESRST,
    output logic                PHASELOCKED,
    output logic                DQS_OE,
    output logic                DQ_OE
);

    localparam int SEQ_MAX  = (LOCK_CYCLES > OSERDES_RST_CYCLES) ? LOCK_CYCLES : OSERDES_RST_CYCLES;
    localparam int CNT_W    = $clog2(SEQ_MAX) + 1;
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int POST_W   = 4;

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_next_cnt;
    logic [SETTLE_W-1:0]  r_settle;
    logic [COARSE_W-1:0]  r_readval;
    logic                 r_bp_d1;
    logic                 r_bp_d2;
    logic                 r_dqs_oe;
    logic [POST_W-1:0]    r_post;

    logic                 w_ready;
    logic                 w_move_ok;
    logic                 w_fine_accept;
    logic                 w_coarse_accept;
    logic [COARSE_W-1:0]  w_coarse_tap;

    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= RESET;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Soft reset always restarts the lock count, from whatever state we are in.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (RST) begin
            w_next_state = LOCK_WAIT;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                RESET: begin
                    w_next_state = LOCK_WAIT;
                    w_next_cnt   = '0;
                end
                LOCK_WAIT: begin
                    if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                        w_next_state = SERDES_RST;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end
                end
                SERDES_RST: begin
                    if (r_cnt == CNT_W'(OSERDES_RST_CYCLES - 1)) begin
                        w_next_state = READY;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end
                end
                READY: begin
                    w_next_cnt = '0;
                end
                default: begin
                    w_next_state = RESET;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    assign w_ready   = (r_state == READY);
    assign w_move_ok = w_ready && (r_settle == '0) && !RST;

    phaser_tap_ctr #(
        .WIDTH (FINE_W),
        .MAX   (FINE_MAX),
        .INIT  (FINE_DELAY)
    ) u_fine (
        .i_clk      (SYSCLK),
        .i_rst_n    (RST_N),
        .i_en       (w_move_ok && FINEENABLE),
        .i_inc      (FINEINC),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_tap      (FINETAP),
        .o_overflow (FINEOVERFLOW),
        .o_accept   (w_fine_accept)
    );

    phaser_tap_ctr #(
        .WIDTH (COARSE_W),
        .MAX   (COARSE_MAX),
        .INIT  (0)
    ) u_coarse (
        .i_clk      (SYSCLK),
        .i_rst_n    (RST_N),
        .i_en       (w_move_ok && COARSEENABLE),
        .i_inc      (COARSEINC),
        .i_load     (w_move_ok && COUNTERLOADEN),
        .i_load_val (COUNTERLOADVAL),
        .o_tap      (w_coarse_tap),
        .o_overflow (COARSEOVERFLOW),
        .o_accept   (w_coarse_accept)
    );

    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_settle  <= '0;
            r_readval <= '0;
        end else begin
            if (w_fine_accept || w_coarse_accept) begin
                r_settle <= SETTLE_W'(SETTLE_CYCLES);
            end else if (r_settle != '0) begin
                r_settle <= r_settle - SETTLE_W'(1);
            end
            if (COUNTERREADEN) begin
                r_readval <= w_coarse_tap;
            end
        end
    end

    // DQS opens one cycle after the burst and stays up through the postamble.
    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bp_d1  <= 1'b0;
            r_bp_d2  <= 1'b0;
            r_dqs_oe <= 1'b0;
            r_post   <= '0;
        end else if (RST || !w_ready) begin
            r_bp_d1  <= 1'b0;
            r_bp_d2  <= 1'b0;
            r_dqs_oe <= 1'b0;
            r_post   <= '0;
        end else begin
            r_bp_d1 <= BURSTPENDING;
            r_bp_d2 <= r_bp_d1;
            if (BURSTPENDING) begin
                r_dqs_oe <= 1'b1;
                r_post   <= POST_W'(POSTAMBLE_CYCLES);
            end else if (r_dqs_oe) begin
                if (r_post == '0) begin
                    r_dqs_oe <= 1'b0;
                end else begin
                    r_post <= r_post - POST_W'(1);
                end
            end
        end
    end

    assign COUNTERREADVAL = r_readval;
    assign OSERDESRST     = !w_ready;
    assign PHASELOCKED    = w_ready && (r_settle == '0);
    assign DQS_OE         = r_dqs_oe && w_ready && !RST;
    assign DQ_OE          = r_bp_d2 && w_ready && !RST;

endmodule

// File: tb/tb_phaser_out_ctl.sv
// Directed bench for phaser_out_ctl: lock sequence, tap saturation and settle,
// coarse load/read-back, burst OE windows and soft reset.
module tb_phaser_out_ctl;

    logic       SYSCLK = 1'b0;
    logic       RST_N;
    logic       RST;
    logic       FINEENABLE;
    logic       FINEINC;
    logic       COARSEENABLE;
    logic       COARSEINC;
    logic       COUNTERLOADEN;
    logic [8:0] COUNTERLOADVAL;
    logic       COUNTERREADEN;
    logic       BURSTPENDING;
    logic [8:0] COUNTERREADVAL;
    logic [5:0] FINETAP;
    logic       FINEOVERFLOW;
    logic       COARSEOVERFLOW;
    logic       OSERDESRST;
    logic       PHASELOCKED;
    logic       DQS_OE;
    logic       DQ_OE;

    int checks = 0;
    int errors = 0;

    always #5 SYSCLK = ~SYSCLK;

    phaser_out_ctl #(
        .FINE_DELAY         (62),
        .COARSE_MAX         (400),
        .LOCK_CYCLES        (32),
        .OSERDES_RST_CYCLES (8),
        .SETTLE_CYCLES      (4),
        .POSTAMBLE_CYCLES   (2)
    ) dut (
        .SYSCLK         (SYSCLK),
        .RST_N          (RST_N),
        .RST            (RST),
        .FINEENABLE     (FINEENABLE),
        .FINEINC        (FINEINC),
        .COARSEENABLE   (COARSEENABLE),
        .COARSEINC      (COARSEINC),
        .COUNTERLOADEN  (COUNTERLOADEN),
        .COUNTERLOADVAL (COUNTERLOADVAL),
        .COUNTERREADEN  (COUNTERREADEN),
        .BURSTPENDING   (BURSTPENDING),
        .COUNTERREADVAL (COUNTERREADVAL),
        .FINETAP        (FINETAP),
        .FINEOVERFLOW   (FINEOVERFLOW),
        .COARSEOVERFLOW (COARSEOVERFLOW),
        .OSERDESRST     (OSERDESRST),
        .PHASELOCKED    (PHASELOCKED),
        .DQS_OE         (DQS_OE),
        .DQ_OE          (DQ_OE)
    );

    // Every step lands 1 ns after a rising edge, so drives and samples sit mid-cycle.
    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic pulseFine(input logic inc);
        FINEENABLE = 1'b1;
        FINEINC    = inc;
        tick();
        FINEENABLE = 1'b0;
    endtask

    task automatic pulseCoarse(input logic inc);
        COARSEENABLE = 1'b1;
        COARSEINC    = inc;
        tick();
        COARSEENABLE = 1'b0;
    endtask

    task automatic loadCoarse(input logic [8:0] val);
        COUNTERLOADVAL = val;
        COUNTERLOADEN  = 1'b1;
        tick();
        COUNTERLOADEN  = 1'b0;
    endtask

    task automatic readCoarse();
        COUNTERREADEN = 1'b1;
        tick();
        COUNTERREADEN = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; RST = 1'b0; FINEENABLE = 1'b0; FINEINC = 1'b0;
        COARSEENABLE = 1'b0; COARSEINC = 1'b0; COUNTERLOADEN = 1'b0;
        COUNTERLOADVAL = '0; COUNTERREADEN = 1'b0; BURSTPENDING = 1'b0;
        repeat (3) tick();
        checks++; if (OSERDESRST !== 1'b1) begin errors++; $display("[TB] FAIL reset_oserdesrst got %b exp 1", OSERDESRST); end
        checks++; if (PHASELOCKED !== 1'b0) begin errors++; $display("[TB] FAIL reset_phaselocked got %b exp 0", PHASELOCKED); end
        checks++; if (DQS_OE !== 1'b0 || DQ_OE !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe got dqs=%b dq=%b exp 0 0", DQS_OE, DQ_OE); end
        checks++; if (FINETAP !== 6'd62) begin errors++; $display("[TB] FAIL reset_finetap got %0d exp 62", FINETAP); end
        checks++; if (COUNTERREADVAL !== 9'd0) begin errors++; $display("[TB] FAIL reset_readval got %0d exp 0", COUNTERREADVAL); end
        checks++; if (FINEOVERFLOW !== 1'b0 || COARSEOVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b %b exp 0 0", FINEOVERFLOW, COARSEOVERFLOW); end
    endtask

    task automatic test_lock();
        int  n;
        bit  plEarly;
        n = 0;
        plEarly = 1'b0;
        RST_N = 1'b1;
        while (n < 200) begin
            tick();
            if (OSERDESRST !== 1'b1) break;
            if (PHASELOCKED !== 1'b0) plEarly = 1'b1;
            n++;
        end
        checks++; if (n != 40) begin errors++; $display("[TB] FAIL lock_oserdesrst_cycles got %0d exp 40", n); end
        checks++; if (plEarly) begin errors++; $display("[TB] FAIL lock_phaselocked_early got 1 exp 0"); end
        checks++; if (PHASELOCKED !== 1'b1) begin errors++; $display("[TB] FAIL lock_phaselocked got %b exp 1", PHASELOCKED); end
        checks++; if (FINETAP !== 6'd62) begin errors++; $display("[TB] FAIL lock_finetap got %0d exp 62", FINETAP); end
        readCoarse();
        checks++; if (COUNTERREADVAL !== 9'd0) begin errors++; $display("[TB] FAIL lock_coarse_read got %0d exp 0", COUNTERREADVAL); end
    endtask

    task automatic test_fine_saturation();
        pulseFine(1'b1);
        checks++; if (FINETAP !== 6'd63) begin errors++; $display("[TB] FAIL fine_sat_first got %0d exp 63", FINETAP); end
        checks++; if (FINEOVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL fine_sat_first_ovf got %b exp 0", FINEOVERFLOW); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (PHASELOCKED !== 1'b0) begin errors++; $display("[TB] FAIL fine_sat_settle_%0d got %b exp 0", i, PHASELOCKED); end
            if (i < 4) tick();
        end
        tick();
        checks++; if (PHASELOCKED !== 1'b1) begin errors++; $display("[TB] FAIL fine_sat_relock got %b exp 1", PHASELOCKED); end
        pulseFine(1'b1);
        checks++; if (FINEOVERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL fine_sat_ovf got %b exp 1", FINEOVERFLOW); end
        checks++; if (FINETAP !== 6'd63) begin errors++; $display("[TB] FAIL fine_sat_hold got %0d exp 63", FINETAP); end
        checks++; if (PHASELOCKED !== 1'b1) begin errors++; $display("[TB] FAIL fine_sat_ovf_nosettle got %b exp 1", PHASELOCKED); end
        tick();
        checks++; if (FINEOVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL fine_sat_ovf_pulse got %b exp 0", FINEOVERFLOW); end
    endtask

    task automatic test_fine_settle_drop();
        for (int i = 0; i < 53; i++) begin
            pulseFine(1'b0);
            repeat (4) tick();
        end
        checks++; if (FINETAP !== 6'd10) begin errors++; $display("[TB] FAIL fine_dec_to10 got %0d exp 10", FINETAP); end
        checks++; if (PHASELOCKED !== 1'b1) begin errors++; $display("[TB] FAIL fine_dec_locked got %b exp 1", PHASELOCKED); end
        pulseFine(1'b1);
        tick();
        pulseFine(1'b1);
        checks++; if (FINETAP !== 6'd11) begin errors++; $display("[TB] FAIL settle_drop_tap got %0d exp 11", FINETAP); end
        checks++; if (FINEOVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL settle_drop_ovf got %b exp 0", FINEOVERFLOW); end
        repeat (4) tick();
        checks++; if (FINETAP !== 6'd11 || PHASELOCKED !== 1'b1) begin errors++; $display("[TB] FAIL settle_drop_final got tap=%0d pl=%b exp 11 1", FINETAP, PHASELOCKED); end
        for (int i = 0; i < 11; i++) begin
            pulseFine(1'b0);
            repeat (4) tick();
        end
        checks++; if (FINETAP !== 6'd0) begin errors++; $display("[TB] FAIL fine_dec_to0 got %0d exp 0", FINETAP); end
        pulseFine(1'b0);
        checks++; if (FINEOVERFLOW !== 1'b1 || FINETAP !== 6'd0) begin errors++; $display("[TB] FAIL fine_underflow got ovf=%b tap=%0d exp 1 0", FINEOVERFLOW, FINETAP); end
        tick();
        checks++; if (FINEOVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL fine_underflow_pulse got %b exp 0", FINEOVERFLOW); end
    endtask

    task automatic test_coarse();
        loadCoarse(9'd300);
        checks++; if (COARSEOVERFLOW !== 1'b0 || PHASELOCKED !== 1'b0) begin errors++; $display("[TB] FAIL coarse_load300 got ovf=%b pl=%b exp 0 0", COARSEOVERFLOW, PHASELOCKED); end
        repeat (4) tick();
        readCoarse();
        checks++; if (COUNTERREADVAL !== 9'd300) begin errors++; $display("[TB] FAIL coarse_read300 got %0d exp 300", COUNTERREADVAL); end
        loadCoarse(9'd511);
        checks++; if (COARSEOVERFLOW !== 1'b1 || PHASELOCKED !== 1'b1) begin errors++; $display("[TB] FAIL coarse_load511 got ovf=%b pl=%b exp 1 1", COARSEOVERFLOW, PHASELOCKED); end
        tick();
        checks++; if (COARSEOVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL coarse_ovf_pulse got %b exp 0", COARSEOVERFLOW); end
        readCoarse();
        checks++; if (COUNTERREADVAL !== 9'd300) begin errors++; $display("[TB] FAIL coarse_read_after_reject got %0d exp 300", COUNTERREADVAL); end
        COUNTERLOADVAL = 9'd123;
        COUNTERLOADEN  = 1'b1;
        COUNTERREADEN  = 1'b1;
        tick();
        COUNTERLOADEN  = 1'b0;
        COUNTERREADEN  = 1'b0;
        checks++; if (COUNTERREADVAL !== 9'd300) begin errors++; $display("[TB] FAIL coarse_read_preload got %0d exp 300", COUNTERREADVAL); end
        repeat (4) tick();
        readCoarse();
        checks++; if (COUNTERREADVAL !== 9'd123) begin errors++; $display("[TB] FAIL coarse_read123 got %0d exp 123", COUNTERREADVAL); end
        loadCoarse(9'd400);
        repeat (4) tick();
        pulseCoarse(1'b1);
        checks++; if (COARSEOVERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL coarse_max_ovf got %b exp 1", COARSEOVERFLOW); end
        tick();
        readCoarse();
        checks++; if (COUNTERREADVAL !== 9'd400) begin errors++; $display("[TB] FAIL coarse_max_hold got %0d exp 400", COUNTERREADVAL); end
        COUNTERLOADVAL = 9'd5;
        COUNTERLOADEN  = 1'b1;
        COARSEENABLE   = 1'b1;
        COARSEINC      = 1'b1;
        tick();
        COUNTERLOADEN  = 1'b0;
        COARSEENABLE   = 1'b0;
        checks++; if (COARSEOVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL coarse_load_priority_ovf got %b exp 0", COARSEOVERFLOW); end
        repeat (4) tick();
        readCoarse();
        checks++; if (COUNTERREADVAL !== 9'd5) begin errors++; $display("[TB] FAIL coarse_load_priority got %0d exp 5", COUNTERREADVAL); end
        FINEENABLE   = 1'b1;
        FINEINC      = 1'b1;
        COARSEENABLE = 1'b1;
        COARSEINC    = 1'b0;
        tick();
        FINEENABLE   = 1'b0;
        COARSEENABLE = 1'b0;
        checks++; if (FINETAP !== 6'd1) begin errors++; $display("[TB] FAIL dual_move_fine got %0d exp 1", FINETAP); end
        repeat (4) tick();
        readCoarse();
        checks++; if (COUNTERREADVAL !== 9'd4) begin errors++; $display("[TB] FAIL dual_move_coarse got %0d exp 4", COUNTERREADVAL); end
        loadCoarse(9'd0);
        repeat (4) tick();
        pulseCoarse(1'b0);
        checks++; if (COARSEOVERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL coarse_underflow got %b exp 1", COARSEOVERFLOW); end
        tick();
        loadCoarse(9'd300);
        repeat (4) tick();
        readCoarse();
        checks++; if (COUNTERREADVAL !== 9'd300) begin errors++; $display("[TB] FAIL coarse_reload300 got %0d exp 300", COUNTERREADVAL); end
    endtask

    task automatic test_burst(input bit twoBursts);
        logic expDqs;
        logic expDq;
        for (int c = 0; c < 26; c++) begin
            if (twoBursts) begin
                expDqs = (c >= 11 && c <= 21);
                expDq  = (c >= 12 && c <= 15) || (c >= 17 && c <= 20);
            end else begin
                expDqs = (c >= 11 && c <= 16);
                expDq  = (c >= 12 && c <= 15);
            end
            checks++; if (DQS_OE !== expDqs) begin errors++; $display("[TB] FAIL burst%0d_dqs_c%0d got %b exp %b", twoBursts, c, DQS_OE, expDqs); end
            checks++; if (DQ_OE !== expDq) begin errors++; $display("[TB] FAIL burst%0d_dq_c%0d got %b exp %b", twoBursts, c, DQ_OE, expDq); end
            BURSTPENDING = (c >= 10 && c <= 13) || (twoBursts && c >= 15 && c <= 18);
            tick();
        end
        BURSTPENDING = 1'b0;
    endtask

    task automatic test_soft_reset();
        int n;
        bit oeLeak;
        bit ovfSeen;
        bit serdesLow;
        oeLeak = 1'b0;
        ovfSeen = 1'b0;
        serdesLow = 1'b0;
        BURSTPENDING = 1'b1;
        repeat (2) tick();
        checks++; if (DQS_OE !== 1'b1 || DQ_OE !== 1'b1) begin errors++; $display("[TB] FAIL srst_pre_oe got dqs=%b dq=%b exp 1 1", DQS_OE, DQ_OE); end
        RST = 1'b1;
        #1;
        checks++; if (DQS_OE !== 1'b0 || DQ_OE !== 1'b0) begin errors++; $display("[TB] FAIL srst_oe_immediate got dqs=%b dq=%b exp 0 0", DQS_OE, DQ_OE); end
        tick();
        RST = 1'b0;
        checks++; if (OSERDESRST !== 1'b1 || PHASELOCKED !== 1'b0) begin errors++; $display("[TB] FAIL srst_state got rst=%b pl=%b exp 1 0", OSERDESRST, PHASELOCKED); end
        n = 0;
        while (n < 100) begin
            FINEENABLE = (n == 5);
            FINEINC    = 1'b1;
            tick();
            n++;
            if (PHASELOCKED === 1'b1) break;
            if (DQS_OE !== 1'b0 || DQ_OE !== 1'b0) oeLeak = 1'b1;
            if (FINEOVERFLOW !== 1'b0) ovfSeen = 1'b1;
            if (OSERDESRST !== 1'b1) serdesLow = 1'b1;
        end
        FINEENABLE   = 1'b0;
        BURSTPENDING = 1'b0;
        checks++; if (n != 40) begin errors++; $display("[TB] FAIL srst_relock_cycles got %0d exp 40", n); end
        checks++; if (oeLeak || ovfSeen || serdesLow) begin errors++; $display("[TB] FAIL srst_during_lock got oe=%b ovf=%b serdeslow=%b exp 0 0 0", oeLeak, ovfSeen, serdesLow); end
        checks++; if (FINETAP !== 6'd1) begin errors++; $display("[TB] FAIL srst_fine_kept got %0d exp 1", FINETAP); end
        readCoarse();
        checks++; if (COUNTERREADVAL !== 9'd300) begin errors++; $display("[TB] FAIL srst_coarse_kept got %0d exp 300", COUNTERREADVAL); end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired got timeout exp finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_lock();
        test_fine_saturation();
        test_fine_settle_drop();
        test_coarse();
        test_burst(1'b0);
        test_burst(1'b1);
        test_soft_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
